// File: rtl/boe_pkg.sv
// Shared types for the branch offset encoder: FSM state and response flags.
package boe_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    RESP = 2'd2
  } boe_state_t;

  // Response flags. At most one is set per response. All zero means a
  // lookup-only miss.
  typedef struct packed {
    logic hit;
    logic is_new;
    logic full;
  } boe_flags_t;

  localparam boe_flags_t BOE_FLAGS_NONE = '0;

endpackage

// File: rtl/boe_table.sv
// Offset table: DEPTH x D register array.
// It has one synchronous write port and one fetch-side combinational read port.
// It also has a second combinational read port, which the encoder's scan uses
// so the scan never steals the fetch port.
// A read of an entry in the same cycle as its write returns the old value.
module boe_table #(
  parameter int D = 8,
  parameter int A = 5
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         we_i,
  input  logic [A-1:0] waddr_i,
  input  logic [D-1:0] wdata_i,
  input  logic [A-1:0] raddr_i,
  output logic [D-1:0] rdata_o,
  input  logic [A-1:0] saddr_i,
  output logic [D-1:0] sdata_o
);

  localparam int DEPTH = 1 << A;

  logic [D-1:0] mem_q [DEPTH];

  // Storage: cleared by reset or clr_i, otherwise written one entry per edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (clr_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];
  assign sdata_o = mem_q[saddr_i];

endmodule

// File: rtl/branch_offset_encoder.sv
// Branch offset encoder: searches the offset table for a requested offset.
// On a miss with allocation enabled, it appends the offset.
// Optional feature macro: BOE_FLUSH_EN adds a flush input that clears the table
// and aborts any request in flight.
// Handshakes: a transfer happens on an edge where valid and ready are both high.
// req_ready is high only in IDLE. rsp_valid stays high with all rsp_* fields
// stable until the edge where rsp_ready is high.
// The decision (hit or miss) is made one edge before rsp_valid rises. The
// table write on an allocating miss happens on that decision edge.
module branch_offset_encoder
  import boe_pkg::*;
#(
  parameter int D = 8,
  parameter int A = 5
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [D-1:0] req_offset,
  input  logic         req_alloc,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [A-1:0] rsp_addr,
  output logic         rsp_hit,
  output logic         rsp_new,
  output logic         rsp_full,
  input  logic [A-1:0] rd_addr,
  output logic [D-1:0] rd_target,
  output logic [A:0]   used_cnt,
`ifdef BOE_FLUSH_EN
  input  logic         flush,
`endif
  output boe_state_t   dbg_state_o
);

  localparam int         DEPTH   = 1 << A;
  localparam logic [A:0] DEPTH_W = (A+1)'(DEPTH);

  boe_state_t   state_q, state_d;
  logic [A:0]   idx_q, idx_d;
  logic [D-1:0] off_q, off_d;
  logic         alloc_q, alloc_d;
  logic [A:0]   used_q, used_d;
  logic         pend_q, pend_d;
  logic [A-1:0] pend_addr_q, pend_addr_d;
  boe_flags_t   pend_flags_q, pend_flags_d;
  logic         rsp_valid_q, rsp_valid_d;
  logic [A-1:0] rsp_addr_q, rsp_addr_d;
  boe_flags_t   rsp_flags_q, rsp_flags_d;

  logic         tbl_we;
  logic         tbl_clr;
  logic [D-1:0] scan_data;
  logic         flush_w;

`ifdef BOE_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  boe_table #(.D(D), .A(A)) u_table (
    .clk_i   (Clk),
    .rst_ni  (Reset_n),
    .clr_i   (tbl_clr),
    .we_i    (tbl_we),
    .waddr_i (used_q[A-1:0]),
    .wdata_i (off_q),
    .raddr_i (rd_addr),
    .rdata_o (rd_target),
    .saddr_i (idx_q[A-1:0]),
    .sdata_o (scan_data)
  );

  // Next-state logic. SCAN visits one entry per cycle. It holds the decision in
  // pend_* for one cycle, then moves it into the response registers.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    off_d        = off_q;
    alloc_d      = alloc_q;
    used_d       = used_q;
    pend_d       = pend_q;
    pend_addr_d  = pend_addr_q;
    pend_flags_d = pend_flags_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_addr_d   = rsp_addr_q;
    rsp_flags_d  = rsp_flags_q;
    tbl_we       = 1'b0;
    tbl_clr      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          off_d   = req_offset;
          alloc_d = req_alloc;
          idx_d   = '0;
          pend_d  = 1'b0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (pend_q) begin
          rsp_valid_d = 1'b1;
          rsp_addr_d  = pend_addr_q;
          rsp_flags_d = pend_flags_q;
          pend_d      = 1'b0;
          state_d     = RESP;
        end else if (idx_q == used_q) begin
          // Every allocated entry has been checked without a match.
          pend_d       = 1'b1;
          pend_addr_d  = '0;
          pend_flags_d = BOE_FLAGS_NONE;
          if (alloc_q) begin
            if (used_q < DEPTH_W) begin
              tbl_we              = 1'b1;
              pend_addr_d         = used_q[A-1:0];
              pend_flags_d.is_new = 1'b1;
              used_d              = used_q + (A+1)'(1);
            end else begin
              pend_flags_d.full = 1'b1;
            end
          end
        end else if (scan_data == off_q) begin
          pend_d           = 1'b1;
          pend_addr_d      = idx_q[A-1:0];
          pend_flags_d     = BOE_FLAGS_NONE;
          pend_flags_d.hit = 1'b1;
        end else begin
          idx_d = idx_q + (A+1)'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_addr_d  = '0;
          rsp_flags_d = BOE_FLAGS_NONE;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Flush beats every other event, including a request in the same cycle.
    if (flush_w) begin
      state_d     = IDLE;
      used_d      = '0;
      pend_d      = 1'b0;
      rsp_valid_d = 1'b0;
      rsp_addr_d  = '0;
      rsp_flags_d = BOE_FLAGS_NONE;
      tbl_we      = 1'b0;
      tbl_clr     = 1'b1;
    end
  end

  // State registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      off_q        <= '0;
      alloc_q      <= 1'b0;
      used_q       <= '0;
      pend_q       <= 1'b0;
      pend_addr_q  <= '0;
      pend_flags_q <= BOE_FLAGS_NONE;
      rsp_valid_q  <= 1'b0;
      rsp_addr_q   <= '0;
      rsp_flags_q  <= BOE_FLAGS_NONE;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      off_q        <= off_d;
      alloc_q      <= alloc_d;
      used_q       <= used_d;
      pend_q       <= pend_d;
      pend_addr_q  <= pend_addr_d;
      pend_flags_q <= pend_flags_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_addr_q   <= rsp_addr_d;
      rsp_flags_q  <= rsp_flags_d;
    end
  end

  assign req_ready   = (state_q == IDLE);
  assign rsp_valid   = rsp_valid_q;
  assign rsp_addr    = rsp_addr_q;
  assign rsp_hit     = rsp_flags_q.hit;
  assign rsp_new     = rsp_flags_q.is_new;
  assign rsp_full    = rsp_flags_q.full;
  assign used_cnt    = used_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_branch_offset_encoder.sv
// Directed bench for branch_offset_encoder (D=8, A=5). With BOE_FLUSH_EN
// defined it also exercises the flush port.
module tb_branch_offset_encoder;
  import boe_pkg::*;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [7:0] req_offset = '0;
  logic       req_alloc = 1'b0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [4:0] rsp_addr;
  logic       rsp_hit;
  logic       rsp_new;
  logic       rsp_full;
  logic [4:0] rd_addr = '0;
  logic [7:0] rd_target;
  logic [5:0] used_cnt;
`ifdef BOE_FLUSH_EN
  logic       flush = 1'b0;
`endif
  boe_state_t dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  // Expected table contents, in allocation order.
  logic [7:0] exp_q[$];

  branch_offset_encoder #(.D(8), .A(5)) dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_offset (req_offset),
    .req_alloc  (req_alloc),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_addr   (rsp_addr),
    .rsp_hit    (rsp_hit),
    .rsp_new    (rsp_new),
    .rsp_full   (rsp_full),
    .rd_addr    (rd_addr),
    .rd_target  (rd_target),
    .used_cnt   (used_cnt),
`ifdef BOE_FLUSH_EN
    .flush      (flush),
`endif
    .dbg_state_o(dbg_state)
  );

  // Clock and watchdog.
  initial forever #5 Clk = ~Clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Reset_n   = 1'b0;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    repeat (2) @(posedge Clk);
    #1 Reset_n = 1'b1;
    exp_q.delete();
  endtask

  task automatic check_table(input string tag);
    for (int i = 0; i < 32; i++) begin
      rd_addr = 5'(i);
      #1;
      check_eq($sformatf("%s_rd%0d", tag, i), rd_target,
               (i < exp_q.size()) ? exp_q[i] : 8'h00);
    end
    tick();
  endtask

  // One full request/response. The response is held for 'hold' cycles first.
  // e_lat counts the edges from the accept edge to the edge where rsp_valid rises.
  task automatic encode(input string tag, input logic [7:0] off, input logic alloc,
                        input logic [4:0] e_addr, input logic e_hit, input logic e_new,
                        input logic e_full, input int e_lat, input int hold);
    int lat;
    req_valid  = 1'b1;
    req_offset = off;
    req_alloc  = alloc;
    tick();
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 60) begin
      tick();
      lat++;
    end
    check_eq({tag, "_lat"}, 32'(lat), 32'(e_lat));
    for (int h = 0; h < hold; h++) begin
      check_eq($sformatf("%s_hold%0d_valid", tag, h), rsp_valid, 1'b1);
      check_eq($sformatf("%s_hold%0d_addr", tag, h), rsp_addr, e_addr);
      check_eq($sformatf("%s_hold%0d_hit", tag, h), rsp_hit, e_hit);
      check_eq($sformatf("%s_hold%0d_rdy", tag, h), req_ready, 1'b0);
      tick();
    end
    check_eq({tag, "_addr"}, rsp_addr, e_addr);
    check_eq({tag, "_hit"}, rsp_hit, e_hit);
    check_eq({tag, "_new"}, rsp_new, e_new);
    check_eq({tag, "_full"}, rsp_full, e_full);
    check_eq({tag, "_busy"}, req_ready, 1'b0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check_eq({tag, "_done_valid"}, rsp_valid, 1'b0);
    check_eq({tag, "_done_addr"}, rsp_addr, 5'd0);
    check_eq({tag, "_done_rdy"}, req_ready, 1'b1);
    if (e_new) exp_q.push_back(off);
  endtask

  initial begin
    // Reset state.
    do_reset();
    check_eq("rst_req_ready", req_ready, 1'b1);
    check_eq("rst_rsp_valid", rsp_valid, 1'b0);
    check_eq("rst_rsp_flags", {rsp_hit, rsp_new, rsp_full}, 3'b000);
    check_eq("rst_used", used_cnt, 6'd0);
    check_eq("rst_state", 32'(dbg_state), 32'(IDLE));
    check_table("rst");

    // Test 1: empty table, allocate 134. This also checks old-then-new on the read port.
    rd_addr    = 5'd0;
    req_valid  = 1'b1;
    req_offset = 8'd134;
    req_alloc  = 1'b1;
    tick();
    req_valid = 1'b0;
    check_eq("t1_rd_old", rd_target, 8'd0);
    check_eq("t1_state", 32'(dbg_state), 32'(SCAN));
    tick();
    check_eq("t1_rd_new", rd_target, 8'd134);
    check_eq("t1_early_valid", rsp_valid, 1'b0);
    check_eq("t1_used", used_cnt, 6'd1);
    tick();
    check_eq("t1_valid", rsp_valid, 1'b1);
    check_eq("t1_addr", rsp_addr, 5'd0);
    check_eq("t1_flags", {rsp_hit, rsp_new, rsp_full}, 3'b010);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check_eq("t1_done_valid", rsp_valid, 1'b0);
    check_eq("t1_done_rdy", req_ready, 1'b1);

    // Test 2: load 6, 15, 8, then look up 8.
    do_reset();
    encode("t2_ld6", 8'd6, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 2, 0);
    encode("t2_ld15", 8'd15, 1'b1, 5'd1, 1'b0, 1'b1, 1'b0, 3, 0);
    encode("t2_ld8", 8'd8, 1'b1, 5'd2, 1'b0, 1'b1, 1'b0, 4, 0);
    encode("t2_hit8", 8'd8, 1'b0, 5'd2, 1'b1, 1'b0, 1'b0, 4, 0);
    check_eq("t2_used", used_cnt, 6'd3);
    check_table("t2");

    // Test 3: negative offset, a lookup-only miss, and offset zero as a real entry.
    do_reset();
    encode("t3_ldm7", 8'hF9, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 2, 0);
    encode("t3_hitm7", 8'hF9, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 2, 0);
    encode("t3_miss9", 8'd9, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 3, 0);
    check_eq("t3_used_a", used_cnt, 6'd1);
    encode("t3_ld0", 8'd0, 1'b1, 5'd1, 1'b0, 1'b1, 1'b0, 3, 0);
    encode("t3_hit0", 8'd0, 1'b0, 5'd1, 1'b1, 1'b0, 1'b0, 3, 0);
    check_eq("t3_used_b", used_cnt, 6'd2);
    check_table("t3");

    // Test 4: fill all 32 entries, then check the full response and a hit on the last entry.
    do_reset();
    for (int i = 0; i < 32; i++)
      encode($sformatf("t4_fill%0d", i), 8'(i * 3 + 1), 1'b1, 5'(i), 1'b0, 1'b1, 1'b0, i + 2, 0);
    check_eq("t4_used_full", used_cnt, 6'd32);
    encode("t4_full", 8'h7F, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 34, 0);
    check_eq("t4_used_sat", used_cnt, 6'd32);
    encode("t4_hit31", 8'd94, 1'b0, 5'd31, 1'b1, 1'b0, 1'b0, 33, 0);
    check_table("t4");

    // Test 5: response held under backpressure, then reset in the middle of a scan.
    do_reset();
    encode("t5_ld5", 8'd5, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 2, 0);
    encode("t5_hold", 8'd5, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 2, 5);
    encode("t5_ld10", 8'd10, 1'b1, 5'd1, 1'b0, 1'b1, 1'b0, 3, 0);
    encode("t5_ld20", 8'd20, 1'b1, 5'd2, 1'b0, 1'b1, 1'b0, 4, 0);
    rd_addr    = 5'd1;
    req_valid  = 1'b1;
    req_offset = 8'd77;
    req_alloc  = 1'b0;
    tick();
    req_valid = 1'b0;
    tick();
    check_eq("t5_mid_state", 32'(dbg_state), 32'(SCAN));
    Reset_n = 1'b0;
    #1;
    check_eq("t5_rst_valid", rsp_valid, 1'b0);
    check_eq("t5_rst_used", used_cnt, 6'd0);
    check_eq("t5_rst_rdy", req_ready, 1'b1);
    check_eq("t5_rst_rd", rd_target, 8'd0);
    @(posedge Clk);
    #1 Reset_n = 1'b1;
    exp_q.delete();
    encode("t5_after", 8'd10, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 2, 0);

`ifdef BOE_FLUSH_EN
    // Test 6: flush during a scan, and a request presented together with flush.
    do_reset();
    encode("t6_ld1", 8'd1, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 2, 0);
    encode("t6_ld2", 8'd2, 1'b1, 5'd1, 1'b0, 1'b1, 1'b0, 3, 0);
    encode("t6_ld3", 8'd3, 1'b1, 5'd2, 1'b0, 1'b1, 1'b0, 4, 0);
    req_valid  = 1'b1;
    req_offset = 8'd99;
    req_alloc  = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    exp_q.delete();
    check_eq("t6_state", 32'(dbg_state), 32'(IDLE));
    check_eq("t6_used", used_cnt, 6'd0);
    check_eq("t6_rdy", req_ready, 1'b1);
    for (int k = 0; k < 6; k++) begin
      check_eq($sformatf("t6_norsp%0d", k), rsp_valid, 1'b0);
      tick();
    end
    check_table("t6");
    req_valid  = 1'b1;
    req_offset = 8'd5;
    flush      = 1'b1;
    tick();
    req_valid = 1'b0;
    flush     = 1'b0;
    check_eq("t6_noaccept", 32'(dbg_state), 32'(IDLE));
    check_eq("t6_noaccept_used", used_cnt, 6'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
